// File: rtl/instmem_pkg.sv
// Shared types, constants and helpers for the loadable instruction memory.
package instmem_pkg;

    typedef enum logic [1:0] {
        StRun,
        StLoad,
        StDone
    } state_e;

    // RV32I canonical NOP (addi x0, x0, 0)
    localparam logic [31:0] NOP_WORD = 32'h00000013;

    // True when a fetch byte address is word aligned, lies inside the
    // 2**addr_w word array, and targets a word that has been loaded.
    function automatic logic addr_in_range(input logic [31:0] a,
                                           input int unsigned addr_w,
                                           input logic [31:0] words_loaded);
        logic [31:0] hi;
        logic [31:0] idx;
        hi  = a >> (addr_w + 2);
        idx = (a >> 2) & ((32'd1 << addr_w) - 32'd1);
        return (a[1:0] == 2'b00) && (hi == 32'd0) && (idx < words_loaded);
    endfunction

endpackage

// File: rtl/instmem_byte_packer.sv
// Assembles four little-endian load bytes into one 32-bit word.
module instmem_byte_packer
    import instmem_pkg::*;
(
    input  logic        clk,
    input  logic        clrn,
    input  logic        clr,
    input  logic        en,
    input  logic [7:0]  data_in,
    output logic [31:0] word,
    output logic        word_stb
);

    logic [1:0]  bidx_q;
    logic [23:0] asm_q;

    // Byte index and the three lower bytes; the 4th byte is taken directly.
    always_ff @(posedge clk) begin
        if (!clrn || clr) begin
            bidx_q <= 2'd0;
            asm_q  <= 24'd0;
        end else if (en) begin
            case (bidx_q)
                2'd0:    asm_q[7:0]   <= data_in;
                2'd1:    asm_q[15:8]  <= data_in;
                2'd2:    asm_q[23:16] <= data_in;
                default: ;
            endcase
            bidx_q <= bidx_q + 2'd1;
        end
    end

    // Complete word is presented in the cycle of its 4th byte transfer.
    always_comb begin
        word     = {data_in, asm_q};
        word_stb = en && (bidx_q == 2'd3);
    end

endmodule

// File: rtl/instmem_loadable_v2.sv
// Byte-serially loadable instruction memory with checked 1-cycle fetch.
module instmem_loadable_v2 #(
    parameter int unsigned ADDR_W   = 8,
    parameter logic [31:0] NOP_WORD = instmem_pkg::NOP_WORD
) (
    input  logic              clk,
    input  logic              clrn,
    input  logic              req,
    input  logic [31:0]       a,
    output logic [31:0]       inst,
    output logic              inst_valid,
    output logic              fetch_err,
    input  logic              ld_start,
    input  logic [ADDR_W:0]   ld_count,
    input  logic [7:0]        ld_byte,
    input  logic              ld_bvalid,
    output logic              ld_bready,
    output logic              ld_busy,
    output logic              ld_done
);
    import instmem_pkg::*;

    localparam int unsigned     WORDS     = 2 ** ADDR_W;
    localparam logic [ADDR_W:0] WORDS_CNT = (ADDR_W + 1)'(WORDS);
    localparam logic [ADDR_W:0] ONE_CNT   = (ADDR_W + 1)'(1);

    state_e              state_q, state_d;
    logic [ADDR_W:0]     cnt_q, cnt_d;
    logic [ADDR_W-1:0]   wptr_q, wptr_d;
    logic [ADDR_W:0]     wl_q, wl_d;

    logic [31:0]         mem [WORDS];
    logic [31:0]         inst_q;
    logic                inst_valid_q;
    logic                fetch_err_q;

    logic                start_acc;
    logic                byte_xfer;
    logic [31:0]         word;
    logic                word_stb;
    logic                fetch_acc;
    logic                fetch_ok;
    logic [ADDR_W-1:0]   fetch_idx;

    assign start_acc = (state_q == StRun) && ld_start;
    assign byte_xfer = ld_bvalid && ld_bready;
    // ld_start has priority over a same-cycle req
    assign fetch_acc = (state_q == StRun) && req && !ld_start;
    assign fetch_ok  = addr_in_range(a, ADDR_W, 32'(wl_q));
    assign fetch_idx = a[ADDR_W+1:2];

    assign ld_bready  = (state_q == StLoad);
    assign ld_busy    = (state_q == StLoad);
    assign ld_done    = (state_q == StDone);
    assign inst       = inst_q;
    assign inst_valid = inst_valid_q;
    assign fetch_err  = fetch_err_q;

    instmem_byte_packer u_packer (
        .clk      (clk),
        .clrn     (clrn),
        .clr      (start_acc),
        .en       (byte_xfer),
        .data_in  (ld_byte),
        .word     (word),
        .word_stb (word_stb)
    );

    // Load FSM and write-side bookkeeping registers.
    always_ff @(posedge clk) begin
        if (!clrn) begin
            state_q <= StRun;
            cnt_q   <= '0;
            wptr_q  <= '0;
            wl_q    <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            wptr_q  <= wptr_d;
            wl_q    <= wl_d;
        end
    end

    // Next state; termination compares the ADDR_W+1 wide word count so a
    // full-depth load ends even though wptr wraps to 0.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        wptr_d  = wptr_q;
        wl_d    = wl_q;
        unique case (state_q)
            StRun: begin
                if (ld_start) begin
                    cnt_d   = (ld_count > WORDS_CNT) ? WORDS_CNT : ld_count;
                    wptr_d  = '0;
                    wl_d    = '0;
                    state_d = (ld_count == '0) ? StDone : StLoad;
                end
            end
            StLoad: begin
                if (word_stb) begin
                    wptr_d = wptr_q + ADDR_W'(1);
                    wl_d   = wl_q + ONE_CNT;
                    if (wl_q + ONE_CNT == cnt_q) begin
                        state_d = StDone;
                    end
                end
            end
            StDone: state_d = StRun;
            default: state_d = StRun;
        endcase
    end

    // Memory write port; contents deliberately survive reset.
    always_ff @(posedge clk) begin
        if ((state_q == StLoad) && word_stb) begin
            mem[wptr_q] <= word;
        end
    end

    // Registered fetch result; reset cancels any in-flight fetch.
    always_ff @(posedge clk) begin
        if (!clrn) begin
            inst_q       <= NOP_WORD;
            inst_valid_q <= 1'b0;
            fetch_err_q  <= 1'b0;
        end else begin
            inst_valid_q <= fetch_acc;
            if (fetch_acc) begin
                fetch_err_q <= !fetch_ok;
                inst_q      <= fetch_ok ? mem[fetch_idx] : NOP_WORD;
            end else begin
                fetch_err_q <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_instmem_loadable_v2.sv
// Scoreboard bench for instmem_loadable_v2 with directed load/fetch vectors.
module tb_instmem_loadable_v2;

    localparam int unsigned ADDR_W = 8;
    localparam logic [31:0] NOP    = 32'h00000013;

    logic              clk = 1'b0;
    logic              clrn;
    logic              req;
    logic [31:0]       a;
    logic [31:0]       inst;
    logic              inst_valid;
    logic              fetch_err;
    logic              ld_start;
    logic [ADDR_W:0]   ld_count;
    logic [7:0]        ld_byte;
    logic              ld_bvalid;
    logic              ld_bready;
    logic              ld_busy;
    logic              ld_done;

    int unsigned n_cmp  = 0;
    int unsigned n_fail = 0;
    logic [32:0] exp_q[$];
    logic [32:0] mon_e;

    instmem_loadable_v2 #(.ADDR_W(ADDR_W)) dut (
        .clk        (clk),
        .clrn       (clrn),
        .req        (req),
        .a          (a),
        .inst       (inst),
        .inst_valid (inst_valid),
        .fetch_err  (fetch_err),
        .ld_start   (ld_start),
        .ld_count   (ld_count),
        .ld_byte    (ld_byte),
        .ld_bvalid  (ld_bvalid),
        .ld_bready  (ld_bready),
        .ld_busy    (ld_busy),
        .ld_done    (ld_done)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Issue one fetch and record the response it must produce.
    task automatic fetch(input logic [31:0] addr, input logic [31:0] exp_inst, input logic exp_err);
        req = 1'b1;
        a   = addr;
        exp_q.push_back({exp_err, exp_inst});
        tick();
        req = 1'b0;
    endtask

    task automatic start_load(input int unsigned count);
        ld_start = 1'b1;
        ld_count = (ADDR_W + 1)'(count);
        tick();
        ld_start = 1'b0;
    endtask

    task automatic send_byte(input logic [7:0] b);
        ld_bvalid = 1'b1;
        ld_byte   = b;
        tick();
        ld_bvalid = 1'b0;
    endtask

    function automatic logic [31:0] big_word(input int unsigned i);
        logic [7:0] lo;
        lo = 8'(i);
        return {16'hC0DE, lo, ~lo};
    endfunction

    // Monitor: every presented result must match the oldest expectation.
    initial begin
        forever begin
            @(negedge clk);
            if (inst_valid === 1'b1) begin
                if (exp_q.size() == 0) begin
                    n_cmp++;
                    n_fail++;
                    $display("FAIL unexpected_valid: inst_valid=1 inst=%h, expected no result", inst);
                end else begin
                    mon_e = exp_q.pop_front();
                    check("fetch_inst", inst, mon_e[31:0]);
                    check("fetch_err", 32'(fetch_err), 32'(mon_e[32]));
                end
            end
        end
    end

    initial begin
        logic [7:0]  prog [8];
        logic [31:0] w;
        prog = '{8'h93, 8'h04, 8'h40, 8'h00, 8'h57, 8'h74, 8'h00, 8'h01};

        clrn = 1'b0; req = 1'b0; a = '0; ld_start = 1'b0; ld_count = '0;
        ld_bvalid = 1'b0; ld_byte = '0;
        repeat (3) tick();
        check("rst_inst", inst, NOP);
        check("rst_inst_valid", 32'(inst_valid), 32'd0);
        check("rst_fetch_err", 32'(fetch_err), 32'd0);
        check("rst_ld_bready", 32'(ld_bready), 32'd0);
        check("rst_ld_busy", 32'(ld_busy), 32'd0);
        check("rst_ld_done", 32'(ld_done), 32'd0);
        clrn = 1'b1;

        // Nothing loaded yet
        fetch(32'h0, NOP, 1'b1);

        // Two-word load with req held high throughout
        start_load(2);
        check("load_busy", 32'(ld_busy), 32'd1);
        check("load_bready", 32'(ld_bready), 32'd1);
        req = 1'b1;
        a   = 32'h0;
        for (int i = 0; i < 8; i++) begin
            check("load_no_valid", 32'(inst_valid), 32'd0);
            check("load_done_early", 32'(ld_done), 32'd0);
            send_byte(prog[i]);
        end
        check("load2_done", 32'(ld_done), 32'd1);
        check("load2_no_valid", 32'(inst_valid), 32'd0);
        tick();
        req = 1'b0;
        check("load2_done_pulse", 32'(ld_done), 32'd0);
        check("load2_not_busy", 32'(ld_busy), 32'd0);
        check("done_no_valid", 32'(inst_valid), 32'd0);

        fetch(32'h0, 32'h00400493, 1'b0);
        fetch(32'h4, 32'h01007457, 1'b0);
        fetch(32'h8, NOP, 1'b1);
        fetch(32'h2, NOP, 1'b1);
        fetch(32'h400, NOP, 1'b1);

        // ld_start beats a same-cycle req
        req = 1'b1; a = 32'h0; ld_start = 1'b1; ld_count = 9'd2;
        tick();
        req = 1'b0; ld_start = 1'b0;
        check("start_wins_busy", 32'(ld_busy), 32'd1);
        check("start_wins_no_valid", 32'(inst_valid), 32'd0);

        // Abort after 6 bytes
        send_byte(8'hAA); send_byte(8'hBB); send_byte(8'hCC);
        send_byte(8'hDD); send_byte(8'hEE); send_byte(8'hFF);
        clrn = 1'b0;
        tick();
        clrn = 1'b1;
        check("abort_not_busy", 32'(ld_busy), 32'd0);
        fetch(32'h0, NOP, 1'b1);

        // Reset cancels an in-flight fetch
        req = 1'b1; a = 32'h0; clrn = 1'b0;
        tick();
        clrn = 1'b1; req = 1'b0;
        check("reset_cancels_fetch", 32'(inst_valid), 32'd0);

        // Fresh load assembles from byte 0 into mem[0]
        start_load(1);
        send_byte(8'h11); send_byte(8'h22); send_byte(8'h33); send_byte(8'h44);
        check("load1_done", 32'(ld_done), 32'd1);
        tick();
        fetch(32'h0, 32'h44332211, 1'b0);
        fetch(32'h4, NOP, 1'b1);

        // Zero-length load
        start_load(0);
        check("load0_done", 32'(ld_done), 32'd1);
        check("load0_not_busy", 32'(ld_busy), 32'd0);
        tick();
        check("load0_done_pulse", 32'(ld_done), 32'd0);
        fetch(32'h0, NOP, 1'b1);

        // Oversized count saturates to the full depth
        start_load(300);
        for (int i = 0; i < 256; i++) begin
            w = big_word(i);
            for (int j = 0; j < 4; j++) begin
                if (i == 255 && j == 3) begin
                    check("full_busy_last", 32'(ld_busy), 32'd1);
                end
                send_byte(w[8*j +: 8]);
            end
        end
        check("full_done", 32'(ld_done), 32'd1);
        tick();
        check("full_not_busy", 32'(ld_busy), 32'd0);
        fetch(32'h3FC, big_word(255), 1'b0);
        fetch(32'h0, big_word(0), 1'b0);
        fetch(32'h200, big_word(128), 1'b0);
        fetch(32'h400, NOP, 1'b1);

        tick();
        tick();
        check("queue_drained", 32'(exp_q.size()), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
